// File: rtl/test_ctrl_if.sv
// Bus bundle between the core side (LSU data port + WB retire strobe) and test_ctrl.
// master: core / bench side, drives strobes, address, store data and retire_valid.
// slave : test_ctrl, returns combinational load data.
interface test_ctrl_if;
  logic        retire_valid;
  logic        mmio_we;
  logic        mmio_re;
  logic [31:0] mmio_addr;
  logic [31:0] mmio_wdata;
  logic [31:0] mmio_rdata;

  modport master (
    output retire_valid, mmio_we, mmio_re, mmio_addr, mmio_wdata,
    input  mmio_rdata
  );

  modport slave (
    input  retire_valid, mmio_we, mmio_re, mmio_addr, mmio_wdata,
    output mmio_rdata
  );
endinterface

// File: rtl/test_ctrl.sv
// Test-completion and watchdog controller: MMIO slave that ends a test as PASS/FAIL/TIMEOUT,
// counts RUN cycles and retires, and halts the core once a terminal state is reached.
// Optional signature FIFO at offsets 0x10/0x14/0x18 built only when TEST_CTRL_SIG_EN is defined.
// Ports:
//   clk, reset      : rising-edge clock, synchronous active-low reset
//   bus (slave)     : retire_valid, mmio_we/re/addr/wdata in, mmio_rdata out (combinational)
//   halt, done      : high in any terminal state
//   pass, fail      : PASS state / FAIL or TIMEOUT state
//   exit_code       : FAIL code, 0 otherwise
//   cycle_cnt       : cycles spent in RUN
//   retire_cnt      : instructions retired in RUN
module test_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
  parameter int          CNT_W       = 32,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned STALL_LIMIT = 64,
  parameter int unsigned SIG_DEPTH   = 8
) (
  input  logic             clk,
  input  logic             reset,
  test_ctrl_if.slave       bus,
  output logic             halt,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [30:0]      exit_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

  localparam logic [4:0] OFF_TOHOST = 5'h00;
  localparam logic [4:0] OFF_CYCLE  = 5'h04;
  localparam logic [4:0] OFF_RETIRE = 5'h08;
  localparam logic [4:0] OFF_STATUS = 5'h0C;
  localparam logic [4:0] OFF_PUSH   = 5'h10;
  localparam logic [4:0] OFF_POP    = 5'h14;
  localparam logic [4:0] OFF_LVL    = 5'h18;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_retire_cnt;
  logic [31:0]      r_stall_cnt;
  logic [30:0]      r_exit_code;

  logic        w_hit;
  logic [4:0]  w_off;
  logic        w_tohost_exit;
  logic        w_cyc_limit;
  logic        w_stall_limit;
  logic [31:0] w_sig_head;
  logic [31:0] w_sig_lvl;
  logic [31:0] w_rdata;

  assign w_hit = (bus.mmio_addr[31:5] == BASE_ADDR[31:5]);
  assign w_off = bus.mmio_addr[4:0];

  // Only odd TOHOST values end the test; even values are ignored so they cannot block a timeout.
  assign w_tohost_exit = bus.mmio_we && w_hit && (w_off == OFF_TOHOST) && bus.mmio_wdata[0];

  // Compare against LIMIT-1 so the limit edge is itself the last counted RUN cycle.
  assign w_cyc_limit   = (TIMEOUT_CYC != 0) &&
                         (r_cycle_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign w_stall_limit = (STALL_LIMIT != 0) && !bus.retire_valid &&
                         (r_stall_cnt == 32'(STALL_LIMIT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_RUN;
    else        r_state <= w_next_state;
  end

  // Next state: TOHOST beats run-length timeout, which beats the stall watchdog.
  always_comb begin
    w_next_state = r_state;
    if (r_state == S_RUN) begin
      if (w_tohost_exit)
        w_next_state = (bus.mmio_wdata == 32'd1) ? S_PASS : S_FAIL;
      else if (w_cyc_limit || w_stall_limit)
        w_next_state = S_TIMEOUT;
    end
  end

  // Outputs.
  always_comb begin
    halt = (r_state != S_RUN);
    done = (r_state != S_RUN);
    pass = (r_state == S_PASS);
    fail = (r_state == S_FAIL) || (r_state == S_TIMEOUT);
  end

  // Counters advance on every RUN edge, including the one that leaves RUN.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cycle_cnt  <= '0;
      r_retire_cnt <= '0;
      r_stall_cnt  <= '0;
      r_exit_code  <= '0;
    end else if (r_state == S_RUN) begin
      r_cycle_cnt  <= r_cycle_cnt + CNT_W'(1);
      r_retire_cnt <= r_retire_cnt + CNT_W'(bus.retire_valid);
      r_stall_cnt  <= bus.retire_valid ? 32'd0 : (r_stall_cnt + 32'd1);
      if (w_next_state == S_FAIL)
        r_exit_code <= bus.mmio_wdata[31:1];
    end
  end

  assign exit_code  = r_exit_code;
  assign cycle_cnt  = r_cycle_cnt;
  assign retire_cnt = r_retire_cnt;

`ifdef TEST_CTRL_SIG_EN
  // SIG_DEPTH must be a power of two >= 2 so pointers wrap naturally.
  localparam int PTR_W = (SIG_DEPTH > 1) ? $clog2(SIG_DEPTH) : 1;

  logic [31:0]    r_sig_mem [SIG_DEPTH];
  logic [PTR_W-1:0] r_sig_rd;
  logic [PTR_W-1:0] r_sig_wr;
  logic [PTR_W:0]   r_sig_cnt;
  logic             r_sig_ovf;
  logic             w_sig_pop;
  logic             w_sig_push_req;
  logic             w_sig_push;
  logic             w_sig_full;

  assign w_sig_full     = (r_sig_cnt == (PTR_W+1)'(SIG_DEPTH));
  assign w_sig_pop      = bus.mmio_re && w_hit && (w_off == OFF_POP) && (r_sig_cnt != '0);
  assign w_sig_push_req = bus.mmio_we && w_hit && (w_off == OFF_PUSH);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_sig_push     = w_sig_push_req && (!w_sig_full || w_sig_pop);

  always_ff @(posedge clk) begin
    if (w_sig_push) r_sig_mem[r_sig_wr] <= bus.mmio_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sig_rd  <= '0;
      r_sig_wr  <= '0;
      r_sig_cnt <= '0;
      r_sig_ovf <= 1'b0;
    end else begin
      if (w_sig_push) r_sig_wr <= r_sig_wr + PTR_W'(1);
      if (w_sig_pop)  r_sig_rd <= r_sig_rd + PTR_W'(1);
      if (w_sig_push && !w_sig_pop)      r_sig_cnt <= r_sig_cnt + (PTR_W+1)'(1);
      else if (!w_sig_push && w_sig_pop) r_sig_cnt <= r_sig_cnt - (PTR_W+1)'(1);
      if (w_sig_push_req && !w_sig_push) r_sig_ovf <= 1'b1;
    end
  end

  assign w_sig_head = (r_sig_cnt != '0) ? r_sig_mem[r_sig_rd] : 32'd0;
  assign w_sig_lvl  = {r_sig_ovf, 31'd0} | 32'(r_sig_cnt);
`else
  logic w_unused_re;
  assign w_unused_re = bus.mmio_re;
  assign w_sig_head  = 32'd0;
  assign w_sig_lvl   = 32'd0;
`endif

  // Load data is a pure function of the address; the pop side effect is gated by mmio_re above.
  always_comb begin
    w_rdata = 32'd0;
    if (w_hit) begin
      case (w_off)
        OFF_CYCLE:  w_rdata = r_cycle_cnt[31:0];
        OFF_RETIRE: w_rdata = r_retire_cnt[31:0];
        OFF_STATUS: w_rdata = {r_exit_code, (r_state != S_RUN)};
        OFF_POP:    w_rdata = w_sig_head;
        OFF_LVL:    w_rdata = w_sig_lvl;
        default:    w_rdata = 32'd0;
      endcase
    end
  end

  assign bus.mmio_rdata = w_rdata;

endmodule

// File: tb/tb_test_ctrl.sv
module tb_test_ctrl;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam int          TO    = 20;
  localparam int          SL    = 4;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        halt, done, pass, fail;
  logic [30:0] exit_code;
  logic [31:0] cycle_cnt, retire_cnt;

  test_ctrl_if bus();

  test_ctrl #(
    .BASE_ADDR(BASE), .CNT_W(32), .TIMEOUT_CYC(TO), .STALL_LIMIT(SL), .SIG_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .halt(halt), .done(done), .pass(pass), .fail(fail),
    .exit_code(exit_code), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        halt, done, pass, fail;
    logic [30:0] code;
    logic [31:0] cyc, ret, rdata;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model: test outcome, counts of RUN cycles / retires / consecutive idle cycles.
  bit          m_run, m_pass, m_fail, m_ovf;
  logic [30:0] m_code;
  logic [31:0] m_cyc, m_ret;
  int          m_idle;
  logic [31:0] m_sig[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_run = 1; m_pass = 0; m_fail = 0; m_ovf = 0;
    m_code = '0; m_cyc = '0; m_ret = '0; m_idle = 0;
    m_sig.delete();
  endtask

  function automatic logic [31:0] m_read(logic [31:0] a);
    if (a[31:5] != BASE[31:5]) return 32'd0;
    case (a[4:0])
      5'h04: return m_cyc;
      5'h08: return m_ret;
      5'h0C: return {m_code, !m_run};
`ifdef TEST_CTRL_SIG_EN
      5'h14: return (m_sig.size() > 0) ? m_sig[0] : 32'd0;
      5'h18: return {m_ovf, 31'd0} | 32'(m_sig.size());
`endif
      default: return 32'd0;
    endcase
  endfunction

  // Called just after a posedge: drive one cycle, record expected outputs, advance model.
  task automatic step(input bit rst_n, input bit rv, input bit we, input bit re,
                      input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    reset            = rst_n;
    bus.retire_valid = rv;
    bus.mmio_we      = we;
    bus.mmio_re      = re;
    bus.mmio_addr    = addr;
    bus.mmio_wdata   = wdata;
    e.halt = !m_run; e.done = !m_run; e.pass = m_pass; e.fail = m_fail;
    e.code = m_code; e.cyc = m_cyc; e.ret = m_ret; e.rdata = m_read(addr);
    sb.push_back(e);
    if (!rst_n) begin
      model_reset();
    end else begin
`ifdef TEST_CTRL_SIG_EN
      if (re && addr == BASE + 32'h14 && m_sig.size() > 0) void'(m_sig.pop_front());
      if (we && addr == BASE + 32'h10) begin
        if (m_sig.size() < DEPTH) m_sig.push_back(wdata);
        else m_ovf = 1;
      end
`endif
      if (m_run) begin
        m_cyc  = m_cyc + 1;
        m_ret  = m_ret + 32'(rv);
        m_idle = rv ? 0 : m_idle + 1;
        if (we && addr == BASE && wdata[0]) begin
          m_run = 0;
          if (wdata == 32'd1) m_pass = 1;
          else begin m_fail = 1; m_code = wdata[31:1]; end
        end else if (m_cyc == TO || m_idle == SL) begin
          m_run = 0; m_fail = 1;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  // Monitor: compares every cycle's outputs mid-cycle against the queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("halt",       halt,           e.halt);
      check("done",       done,           e.done);
      check("pass",       pass,           e.pass);
      check("fail",       fail,           e.fail);
      check("exit_code",  exit_code,      e.code);
      check("cycle_cnt",  cycle_cnt,      e.cyc);
      check("retire_cnt", retire_cnt,     e.ret);
      check("rdata",      bus.mmio_rdata, e.rdata);
    end
  end

  logic [31:0] offs [8] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C};

  initial begin
    logic [31:0] a, d;
    reset = 1'b0;
    bus.retire_valid = 0; bus.mmio_we = 0; bus.mmio_re = 0;
    bus.mmio_addr = '0; bus.mmio_wdata = '0;
    @(posedge clk); #1;
    model_reset();
    check("reset_halt", halt, 0);
    check("reset_cyc",  cycle_cnt, 0);

    // T1: 5 retires then TOHOST=1
    step(0, 0, 0, 0, BASE, 0);
    repeat (5) step(1, 1, 0, 0, BASE + 4, 0);
    step(1, 0, 1, 0, BASE, 1);
    check("t1_pass", pass, 1);
    check("t1_halt", halt, 1);
    check("t1_fail", fail, 0);
    check("t1_ret",  retire_cnt, 5);
    check("t1_code", exit_code, 0);
    step(1, 1, 0, 1, BASE + 12, 0);

    // T2: fail code, later pass ignored
    step(0, 0, 0, 0, BASE, 0);
    step(1, 1, 1, 0, BASE, 32'h7);
    check("t2_fail", fail, 1);
    check("t2_code", exit_code, 3);
    step(1, 1, 1, 0, BASE, 32'h1);
    check("t2_nopass", pass, 0);

    // T3: run-length timeout after exactly TO cycles
    step(0, 0, 0, 0, BASE, 0);
    repeat (TO - 1) step(1, 1, 0, 0, BASE + 12, 0);
    check("t3_early", fail, 0);
    step(1, 1, 0, 0, BASE + 12, 0);
    check("t3_fail", fail, 1);
    check("t3_cyc",  cycle_cnt, TO);
    bus.mmio_addr = BASE + 12; #1;
    check("t3_status", bus.mmio_rdata, 1);

    // T4: stall watchdog, then a retire at cycle 3 pushes it out by 4
    step(0, 0, 0, 0, BASE, 0);
    repeat (SL - 1) step(1, 0, 0, 0, BASE + 8, 0);
    check("t4_early", fail, 0);
    step(1, 0, 0, 0, BASE + 8, 0);
    check("t4_fail", fail, 1);
    check("t4_cyc",  cycle_cnt, SL);
    step(0, 0, 0, 0, BASE, 0);
    repeat (3) step(1, 0, 0, 0, BASE, 0);
    step(1, 1, 0, 0, BASE, 0);
    repeat (3) step(1, 0, 0, 0, BASE, 0);
    check("t4_delay", fail, 0);
    step(1, 0, 0, 0, BASE, 0);
    check("t4_late", fail, 1);
    check("t4_cyc8", cycle_cnt, 8);

    // T5: TOHOST wins over timeout; reset out of a terminal state
    step(0, 0, 0, 0, BASE, 0);
    repeat (TO - 1) step(1, 1, 0, 0, BASE, 0);
    step(1, 1, 1, 0, BASE, 1);
    check("t5_pass", pass, 1);
    check("t5_fail", fail, 0);
    step(1, 1, 0, 0, BASE, 0);
    step(0, 1, 0, 0, BASE + 4, 0);
    check("t5_rst_halt", halt, 0);
    check("t5_rst_pass", pass, 0);
    check("t5_rst_cyc",  cycle_cnt, 0);
    step(1, 1, 0, 0, BASE + 4, 0);
    check("t5_restart_cyc", cycle_cnt, 1);
    check("t5_restart_ret", retire_cnt, 1);

    // Ignored writes: even TOHOST, other offsets, misaligned, wrong base
    step(1, 1, 1, 0, BASE, 32'h2);
    step(1, 1, 1, 0, BASE + 4, 32'h1);
    step(1, 1, 1, 0, BASE + 2, 32'h1);
    step(1, 1, 1, 0, 32'h1234_0000, 32'h1);
    check("ign_done", done, 0);

`ifdef TEST_CTRL_SIG_EN
    // T6: overflow then ordered drain
    step(0, 0, 0, 0, BASE, 0);
    for (int i = 1; i <= DEPTH + 1; i++) step(1, 1, 1, 0, BASE + 16, 32'(i));
    bus.mmio_addr = BASE + 24; #1;
    check("t6_lvl", bus.mmio_rdata, 32'h8000_0008);
    for (int i = 1; i <= DEPTH + 1; i++) begin
      bus.mmio_addr = BASE + 20; #1;
      check("t6_pop", bus.mmio_rdata, (i <= DEPTH) ? 32'(i) : 32'd0);
      step(1, 1, 0, 1, BASE + 20, 0);
    end
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      a = (($urandom % 8) == 0) ? $urandom : BASE + offs[$urandom % 8];
      case ($urandom % 4)
        0:       d = 32'd1;
        1:       d = $urandom | 32'd1;
        default: d = $urandom & 32'hFFFF_FFFE;
      endcase
      step(($urandom % 30) != 0, ($urandom % 5) != 0, ($urandom % 5) == 0,
           ($urandom % 2) == 0, a, d);
    end

    step(1, 0, 0, 0, BASE, 0);
    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
